// File: rtl/game_sequencer.sv
// game_sequencer: frame-synchronised game sequencer.
// Each frame_tick runs NUM_UNITS update units in order through an enable/done
// handshake. After the units it resolves collision/scoring for one cycle, then
// manages lives, respawn, pause and game-over.
module game_sequencer #(
    parameter int unsigned NUM_UNITS = 2,
    parameter int unsigned SCORE_W   = 8,
    parameter int unsigned LIVES     = 3,
    localparam int unsigned LIVES_W  = $clog2(LIVES + 1)
) (
    input  logic                 clk,
    input  logic                 resetGame_n,
    input  logic                 press,
    input  logic                 pause_req,
    input  logic                 frame_tick,
    input  logic [NUM_UNITS-1:0] unit_done,
    input  logic                 collision,
    input  logic                 pass_pipe,
    output logic [NUM_UNITS-1:0] update_en,
    output logic                 respawn,
    output logic [SCORE_W-1:0]   score,
    output logic [LIVES_W-1:0]   lives,
    output logic [2:0]           game_state,
    output logic                 overrun
);

    // Unit index width; at least one bit so a single-unit build still has a counter.
    localparam int unsigned KW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam logic [KW-1:0] LastUnit = KW'(NUM_UNITS - 1);

    // Encoding doubles as the game_state output value.
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StWait   = 3'd1,
        StUpdate = 3'd2,
        StLogic  = 3'd3,
        StOver   = 3'd4,
        StPause  = 3'd5
    } state_e;

    state_e          state_q;
    logic [KW-1:0]   k_q;
    logic            press_q;
    logic            pause_q;
    logic            press_edge;
    logic            pause_edge;

    assign press_edge = press & ~press_q;
    assign pause_edge = pause_req & ~pause_q;
    assign game_state = state_q;

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge resetGame_n) begin
        if (!resetGame_n) begin
            state_q   <= StIdle;
            k_q       <= '0;
            press_q   <= 1'b0;
            pause_q   <= 1'b0;
            update_en <= '0;
            respawn   <= 1'b0;
            score     <= '0;
            lives     <= '0;
            overrun   <= 1'b0;
        end else begin
            press_q <= press;
            pause_q <= pause_req;
            respawn <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (press_edge) begin
                        state_q <= StWait;
                        score   <= '0;
                        lives   <= LIVES_W'(LIVES);
                        overrun <= 1'b0;
                    end
                end

                StWait: begin
                    // Tick wins over a simultaneous pause edge.
                    if (frame_tick) begin
                        state_q   <= StUpdate;
                        k_q       <= '0;
                        update_en <= NUM_UNITS'(1);
                    end else if (pause_edge) begin
                        state_q <= StPause;
                    end
                end

                StPause: begin
                    if (pause_edge) begin
                        state_q <= StWait;
                    end
                end

                StUpdate: begin
                    // A tick here cannot be honoured; flag it and drop it.
                    if (frame_tick) begin
                        overrun <= 1'b1;
                    end
                    if (unit_done[k_q]) begin
                        if (k_q == LastUnit) begin
                            state_q   <= StLogic;
                            update_en <= '0;
                        end else begin
                            k_q       <= k_q + 1'b1;
                            update_en <= update_en << 1;
                        end
                    end
                end

                StLogic: begin
                    if (frame_tick) begin
                        overrun <= 1'b1;
                    end
                    // Collision has priority; a same-cycle pass is not scored.
                    if (collision) begin
                        if (lives == LIVES_W'(1)) begin
                            lives   <= '0;
                            state_q <= StOver;
                        end else begin
                            lives   <= lives - 1'b1;
                            respawn <= 1'b1;
                            state_q <= StWait;
                        end
                    end else begin
                        if (pass_pipe && (score != '1)) begin
                            score <= score + 1'b1;
                        end
                        state_q <= StWait;
                    end
                end

                StOver: begin
                    if (press_edge) begin
                        state_q <= StIdle;
                    end
                end

                default: begin
                    state_q   <= StIdle;
                    update_en <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed/randomised bench for game_sequencer with a game-level reference model.
module tb_game_sequencer;

    localparam int NU = 2;

    logic          clk = 1'b0;
    logic          resetGame_n;
    logic          press;
    logic          pause_req;
    logic          frame_tick;
    logic [NU-1:0] unit_done;
    logic          collision;
    logic          pass_pipe;
    logic [NU-1:0] update_en;
    logic          respawn;
    logic [7:0]    score;
    logic [1:0]    lives;
    logic [2:0]    game_state;
    logic          overrun;

    int total = 0;
    int bad   = 0;

    // Reference model: plain game quantities.
    int m_state;
    int m_score;
    int m_lives;
    int m_ov;

    always #5 clk = ~clk;

    game_sequencer #(
        .NUM_UNITS(NU),
        .SCORE_W  (8),
        .LIVES    (3)
    ) dut (
        .clk        (clk),
        .resetGame_n(resetGame_n),
        .press      (press),
        .pause_req  (pause_req),
        .frame_tick (frame_tick),
        .unit_done  (unit_done),
        .collision  (collision),
        .pass_pipe  (pass_pipe),
        .update_en  (update_en),
        .respawn    (respawn),
        .score      (score),
        .lives      (lives),
        .game_state (game_state),
        .overrun    (overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_state"}, 32'(game_state), 32'(m_state));
        check({tag, "_score"}, 32'(score), 32'(m_score));
        check({tag, "_lives"}, 32'(lives), 32'(m_lives));
        check({tag, "_ovr"}, 32'(overrun), 32'(m_ov));
    endtask

    // One frame from S_WAIT: units finish after d0/d1 wait cycles, then logic resolves.
    task automatic do_frame(input int d0, input int d1, input bit col, input bit pas,
                            input bit pz, input bit ov);
        int d[NU];
        logic [NU-1:0] mask;
        bit exp_resp;
        d[0] = d0;
        d[1] = d1;
        exp_resp = 1'b0;
        frame_tick = 1'b1;
        collision  = col;
        pass_pipe  = pas;
        unit_done  = '0;
        if (pz) pause_req = 1'b1;
        step();
        frame_tick = 1'b0;
        for (int u = 0; u < NU; u++) begin
            mask = NU'(1) << u;
            for (int c = 0; c < d[u]; c++) begin
                check("upd_wait_en", 32'(update_en), 32'(mask));
                check("upd_wait_st", 32'(game_state), 32'd2);
                unit_done = NU'($urandom) & ~mask;
                if (ov && u == 0 && c == 0) begin
                    frame_tick = 1'b1;
                    m_ov = 1;
                end
                step();
                frame_tick = 1'b0;
            end
            check("upd_en", 32'(update_en), 32'(mask));
            unit_done = mask;
            step();
        end
        unit_done = '0;
        check("logic_st", 32'(game_state), 32'd3);
        check("logic_en", 32'(update_en), 32'd0);
        step();
        if (col) begin
            if (m_lives == 1) begin
                m_lives = 0;
                m_state = 4;
            end else begin
                m_lives--;
                m_state = 1;
                exp_resp = 1'b1;
            end
        end else begin
            if (pas && m_score < 255) m_score++;
            m_state = 1;
        end
        check_model("frame");
        check("respawn", 32'(respawn), 32'(exp_resp));
        step();
        check("respawn_off", 32'(respawn), 32'd0);
        check("frame_hold", 32'(game_state), 32'(m_state));
        collision = 1'b0;
        pass_pipe = 1'b0;
        if (pz) pause_req = 1'b0;
    endtask

    task automatic press_edge();
        press = 1'b1;
        step();
        press = 1'b0;
        step();
    endtask

    initial begin
        resetGame_n = 1'b0;
        press       = 1'b0;
        pause_req   = 1'b0;
        frame_tick  = 1'b0;
        unit_done   = '0;
        collision   = 1'b0;
        pass_pipe   = 1'b0;
        m_state = 0;
        m_score = 0;
        m_lives = 0;
        m_ov    = 0;
        step();
        step();
        check("rst_en", 32'(update_en), 32'd0);
        check("rst_resp", 32'(respawn), 32'd0);
        check_model("rst");
        resetGame_n = 1'b1;
        step();

        // Held press: exactly one IDLE->WAIT transition.
        press = 1'b1;
        step();
        m_state = 1;
        m_lives = 3;
        m_score = 0;
        check_model("start");
        step();
        check_model("start_hold1");
        step();
        check_model("start_hold2");
        press = 1'b0;
        step();

        // Minimum-latency frame and a slow unit 0.
        do_frame(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_frame(5, 0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Score saturation over many passed pipes.
        for (int f = 0; f < 300; f++) begin
            do_frame(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                     1'b0, 1'b1, 1'b0, 1'b0);
        end
        check("score_sat", 32'(score), 32'd255);

        // Collision beats pass.
        do_frame(1, 2, 1'b1, 1'b1, 1'b0, 1'b0);

        // Pause in WAIT, ticks ignored while paused.
        pause_req = 1'b1;
        step();
        m_state = 5;
        check_model("pause_in");
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check_model("pause_tick");
        press = 1'b1;
        step();
        press = 1'b0;
        pause_req = 1'b0;
        step();
        check_model("pause_hold");
        pause_req = 1'b1;
        step();
        m_state = 1;
        check_model("pause_out");
        pause_req = 1'b0;
        step();

        // Tick and pause edge together: tick wins, held pause not latched later.
        do_frame(0, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        check("no_late_pause", 32'(game_state), 32'd1);

        // Tick during UPDATE sets overrun and is dropped.
        do_frame(2, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        check("tick_dropped", 32'(game_state), 32'd1);

        // Remaining lives lost: 2 -> 1 -> 0 and game over.
        do_frame(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        do_frame(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("over_state", 32'(game_state), 32'd4);
        press_edge();
        m_state = 0;
        check_model("over_to_idle");

        // New game clears score and overrun.
        press_edge();
        m_state = 1;
        m_score = 0;
        m_lives = 3;
        m_ov    = 0;
        check_model("restart");

        // Asynchronous reset mid-UPDATE.
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check("pre_rst_en", 32'(update_en), 32'd1);
        #2;
        resetGame_n = 1'b0;
        #1;
        m_state = 0;
        m_score = 0;
        m_lives = 0;
        check("arst_en", 32'(update_en), 32'd0);
        check_model("arst");
        step();
        resetGame_n = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
